// File: rtl/cb_mem_bank_cfg_ctrl_pkg.sv
// cb_cfg_ctrl_pkg: shared state type and sizing helpers for the memory-bank config sequencer
package cb_cfg_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, SETUP, WRITE, HOLD, DONE} cfg_state_e;
   function automatic int calc_beats(input int num_bl, input int din_w);
      return (num_bl + din_w - 1) / din_w;
   endfunction
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/cb_mem_bank_cfg_ctrl_bl_word_assembler.sv
// bl_word_assembler: packs DIN_W-bit beats into one NUM_BL-bit bit-line word
module bl_word_assembler
   import cb_cfg_ctrl_pkg::*;
#(
   parameter int NUM_BL = 72,
   parameter int DIN_W  = 8
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [DIN_W-1:0]  din,
   output logic [NUM_BL-1:0] bl,
   output logic              last_beat
);
   localparam int BEATS = calc_beats(NUM_BL, DIN_W);
   localparam int BW = cnt_w(BEATS);
   logic [BW-1:0] beat;
   assign last_beat = beat == BW'(BEATS - 1);
   // beat counter: advances per stored beat and wraps after the last one of a row
   always_ff @(posedge prog_clk or negedge prog_rst_n)
      if (!prog_rst_n) beat <= '0;
      else if (clr) beat <= '0;
      else if (wr_en) beat <= last_beat ? '0 : beat + BW'(1);
   // bit-line word: cleared for a new pass, one slice written per beat, bits past NUM_BL dropped
   always_ff @(posedge prog_clk or negedge prog_rst_n)
      if (!prog_rst_n) bl <= '0;
      else if (clr) bl <= '0;
      else if (wr_en)
         for (int j = 0; j < DIN_W; j++)
            if (int'(beat) * DIN_W + j < NUM_BL) bl[int'(beat) * DIN_W + j] <= din[j];
endmodule

// File: rtl/cb_mem_bank_cfg_ctrl.sv
// cb_mem_bank_cfg_ctrl: loads BL words from a byte stream and pulses WL rows to program an SRAM bank
module cb_mem_bank_cfg_ctrl
   import cb_cfg_ctrl_pkg::*;
#(
   parameter int NUM_BL   = 72,
   parameter int NUM_WL   = 1,
   parameter int DIN_W    = 8,
   parameter int WL_PULSE = 2
) (
   input  logic              prog_clk,
   input  logic              prog_rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DIN_W-1:0]  cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic [NUM_BL-1:0] bl,
   output logic [NUM_WL-1:0] wl,
   output logic              busy,
   output logic              done
);
   localparam int RW = cnt_w(NUM_WL);
   cfg_state_e state, state_nx;
   logic [RW-1:0] row;
   logic [3:0] pulse;
   logic begin_pass, accept, last_beat, last_row, pulse_end;
   assign begin_pass = state == IDLE && start && !abort;
   assign accept = cfg_valid && cfg_ready && !abort;
   assign last_row = row == RW'(NUM_WL - 1);
   assign pulse_end = pulse == 4'(WL_PULSE - 1);
   assign cfg_ready = state == LOAD;
   assign busy = state != IDLE;
   assign done = state == DONE;
   bl_word_assembler #(.NUM_BL(NUM_BL), .DIN_W(DIN_W)) u_asm (
      .prog_clk  (prog_clk),
      .prog_rst_n(prog_rst_n),
      .clr       (begin_pass),
      .wr_en     (accept),
      .din       (cfg_data),
      .bl        (bl),
      .last_beat (last_beat)
   );
   // next state: walk LOAD/SETUP/WRITE/HOLD per row; abort returns to IDLE from anywhere
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? LOAD : IDLE;
         LOAD:    state_nx = (accept && last_beat) ? SETUP : LOAD;
         SETUP:   state_nx = WRITE;
         WRITE:   state_nx = pulse_end ? HOLD : WRITE;
         HOLD:    state_nx = last_row ? DONE : LOAD;
         default: state_nx = IDLE;
      endcase
      if (abort) state_nx = IDLE;
   end
   // state, row index, pulse timer and registered one-hot word line
   always_ff @(posedge prog_clk or negedge prog_rst_n)
      if (!prog_rst_n) begin
         state <= IDLE;
         row   <= '0;
         pulse <= '0;
         wl    <= '0;
      end else begin
         state <= state_nx;
         row   <= begin_pass ? '0 : (state == HOLD && !last_row && !abort) ? row + RW'(1) : row;
         pulse <= (state == WRITE) ? pulse + 4'd1 : 4'd0;
         wl    <= (state_nx == WRITE) ? NUM_WL'(1) << row : '0;
      end
endmodule

// File: doc/cb_mem_bank_cfg_ctrl.md
Name: cb_mem_bank_cfg_ctrl

Overview:
- Configuration sequencer for a memory-bank (BL/WL) programmed routing tile, such as a connection block built from mux2_size8 instances and their SRAM banks.
- Accepts a bitstream over a valid/ready byte stream and assembles one full BL word per row.
- Pulses the matching WL line for each row in turn.
- Signals completion once all rows are written; sits between the chip-level configuration port and the tile's bl/wl inputs.

Parameters:
- NUM_BL, 72, bit-line width; must equal the tile's bl width.
- NUM_WL, 1, number of word-line rows to program, row 0 first.
- DIN_W, 8, bitstream beat width.
- WL_PULSE, 2, WL high time in cycles; legal range 1..15.

Ports:
- prog_clk  in  1  programming clock; all state changes on its rising edge.
- prog_rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a configuration pass; sampled in IDLE only.
- abort  in  1  synchronous cancel; takes effect in any state.
- cfg_data  in  DIN_W  bitstream beat.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  controller accepts a beat this cycle.
- bl  out  NUM_BL  bit-line drive, registered.
- wl  out  NUM_WL  word-line drive, registered, at most one bit high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a full pass.

Behaviour:
- Reset values: cfg_ready=0, bl=0, wl=0, busy=0, done=0, state=IDLE, row=0, beat=0.
- Constants: BEATS = ceil(NUM_BL/DIN_W). Beat counter width is clog2(BEATS+1); row counter width is clog2(NUM_WL+1).
- Bit mapping: in beat k, cfg_data[j] goes to bl[k*DIN_W+j]. Bits whose index is NUM_BL or higher are discarded.
- IDLE:
  - start=1 moves to LOAD next cycle.
  - On that transition, bl is cleared to 0, and row and beat are set to 0.
- LOAD:
  - cfg_ready=1 for the whole state.
  - Each cycle with cfg_valid&&cfg_ready stores one beat and increments beat.
  - The handshake that stores beat BEATS-1 moves to SETUP; beat returns to 0.
  - Stalls on cfg_valid=0 have unbounded length and do not alter stored bits.
- SETUP: one cycle; bl is stable, wl=0.
- WRITE:
  - wl[row]=1 for exactly WL_PULSE cycles; all other wl bits stay 0.
  - bl must not change during WRITE.
- HOLD: one cycle with wl=0 and bl unchanged (hold-time margin).
  - If row==NUM_WL-1, next state is DONE.
  - Otherwise row increments and the next state is LOAD.
- DONE:
  - done=1 and busy=1 for one cycle, then IDLE.
  - bl keeps the last row's value until the next start.
- start while busy is ignored and has no side effect.
- abort=1 in any non-IDLE state:
  - Next cycle is IDLE with wl=0 and cfg_ready=0; done is not pulsed.
  - bl keeps its current value.
  - abort in IDLE is ignored. If start and abort are both high in IDLE, abort wins and the block stays in IDLE.
- A beat offered on the same cycle abort is high is not consumed: cfg_ready drops the next cycle, and the abort cycle's handshake is ignored.
- Reset asserted mid-pass (any state) returns immediately to the reset values. wl is forced low asynchronously, so no partial WL pulse survives.
- Single-row pass latency with no stalls (start sampled at cycle 0):
  - LOAD occupies cycles 1..BEATS.
  - SETUP is at BEATS+1.
  - WRITE occupies BEATS+2 .. BEATS+1+WL_PULSE.
  - HOLD is at BEATS+2+WL_PULSE.
  - done pulses at BEATS+3+WL_PULSE.

Decomposition:
- Package cb_cfg_ctrl_pkg holds:
  - the state enum: IDLE, LOAD, SETUP, WRITE, HOLD, DONE;
  - a localparam function computing BEATS;
  - the counter-width helper.
- One natural sub-module, bl_word_assembler, containing:
  - the beat counter;
  - the indexed write of DIN_W bits into the NUM_BL register, with clear;
  - a last_beat output.
- The FSM, row counter, WL pulse counter and one-hot wl decode stay in the top module.

Test Plan:
- Defaults, start at cycle 0, 9 beats 0x01..0x09 back-to-back:
  - bl[0:7]=0x01 … bl[64:71]=0x09.
  - wl[0]=1 on cycles 11-12 only.
  - done pulses at cycle 14; busy falls at cycle 15.
- Same pass with cfg_valid low for 5 cycles between beats 3 and 4:
  - bl is identical to the first test; all later events are shifted by 5 cycles.
  - cfg_ready stays high throughout LOAD.
- NUM_WL=3, rows of all-0xFF, all-0x00, 0xA5 repeated:
  - wl[0], wl[1], wl[2] each pulse 2 cycles, in order, never overlapping.
  - bl during each pulse equals that row's data.
  - Exactly one done pulse.
- abort asserted on the first WRITE cycle:
  - wl=0 next cycle, state IDLE, no done pulse.
  - A new start then completes a clean pass.
- prog_rst_n pulled low mid-LOAD and mid-WRITE:
  - wl, bl, busy and cfg_ready go to 0 without waiting for a clock edge.
  - After release the block is idle and ignores cfg_valid.
- NUM_BL=20, DIN_W=8:
  - 3 beats are required.
  - Upper 4 bits of beat 2 are discarded; bl[16:19] equals beat2[3:0].
